// File: rtl/tick_monitor_pkg.sv
// Shared types and limit calculation for the slow-clock tick monitor.
package tick_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] tmo;
    } limits_t;

    // Acceptance window and timeout, in fast-clock cycles, using integer division.
    function automatic limits_t calc_limits(input int freq_in, input int freq_exp, input int tol_pct);
        limits_t lim;
        int      exp_cnt;
        int      dev;
        exp_cnt = freq_in / freq_exp;
        dev     = exp_cnt * tol_pct / 100;
        lim.lo  = 32'(exp_cnt - dev);
        lim.hi  = 32'(exp_cnt + dev);
        lim.tmo = 32'(2 * exp_cnt);
        return lim;
    endfunction

endpackage

// File: rtl/tick_monitor_sync_edge.sv
// Three-flop synchronizer with rising-edge detect; also used for buttons.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/tick_monitor.sv
// Tick monitor: turns a slow divided clock into one-cycle tick enables on
// clkd, measures its period and flags out-of-tolerance or stuck input.
// Optional duty-cycle check enabled by defining TICK_MONITOR_DUTY_CHECK_EN.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int FREQ_IN  = 50000000,
    parameter int FREQ_EXP = 5,
    parameter int TOL_PCT  = 10,
    parameter int CNT_W    = 25
) (
    input  logic             clkd,
    input  logic             rst_n,
    input  logic             clk_slow,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
`ifdef TICK_MONITOR_DUTY_CHECK_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam limits_t          LIM = calc_limits(FREQ_IN, FREQ_EXP, TOL_PCT);
    localparam logic [CNT_W-1:0] LO  = CNT_W'(LIM.lo);
    localparam logic [CNT_W-1:0] HI  = CNT_W'(LIM.hi);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(LIM.tmo);

    state_t           state;
    state_t           next_state;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       good_cnt;
    logic             in_range;
    logic             period_ok;
    logic             timeout;
    logic             report;
    logic             judge_bad;
    logic             do_lock;

`ifdef TICK_MONITOR_DUTY_CHECK_EN
    localparam int DW = CNT_W + 8;

    logic             level;
    logic [CNT_W-1:0] high_cnt;
    logic [DW-1:0]    high_scaled;
    logic [DW-1:0]    duty_lo;
    logic [DW-1:0]    duty_hi;
    logic             duty_ok;
`else
    logic             level_unused;
`endif

    sync_edge u_sync (
        .clk   (clkd),
        .rst_n (rst_n),
        .din   (clk_slow),
`ifdef TICK_MONITOR_DUTY_CHECK_EN
        .level (level),
`else
        .level (level_unused),
`endif
        .rise  (rise)
    );

    // Cycles since the last rise; restarts at 1 on a rise and parks at the timeout value.
    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt != TMO) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef TICK_MONITOR_DUTY_CHECK_EN
    // High-phase length of the current slow period; the rise cycle itself counts as high.
    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            high_cnt <= '0;
        end else if (rise) begin
            high_cnt <= CNT_W'(1);
        end else if (level && (high_cnt != TMO)) begin
            high_cnt <= high_cnt + CNT_W'(1);
        end
    end

    // Duty window period/2 +/- tolerance, compared as 200*high against period*(100 +/- tol).
    always_comb begin
        high_scaled = DW'(high_cnt) * DW'(200);
        duty_lo     = DW'(cnt) * DW'(100 - TOL_PCT);
        duty_hi     = DW'(cnt) * DW'(100 + TOL_PCT);
        duty_ok     = (high_scaled >= duty_lo) && (high_scaled <= duty_hi);
    end
`endif

    // FSM state register.
    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; a rise takes priority over a simultaneous timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (period_ok && (good_cnt == 2'd1)) begin
                        next_state = LOCKED;
                    end
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!period_ok) begin
                        next_state = MEASURE;
                    end
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM output decode: which measurement events happen this cycle.
    always_comb begin
        in_range = (cnt >= LO) && (cnt <= HI);
`ifdef TICK_MONITOR_DUTY_CHECK_EN
        period_ok = in_range && duty_ok;
`else
        period_ok = in_range;
`endif
        timeout   = (cnt == TMO) && !rise && (state != IDLE);
        report    = rise && (state != IDLE);
        judge_bad = report && !period_ok;
        do_lock   = report && period_ok && (state == MEASURE) && (good_cnt == 2'd1);
    end

    // Registered outputs and good-period bookkeeping driven by the decoded events.
    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            tick         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
            good_cnt     <= 2'd0;
        end else begin
            tick         <= rise;
            period_valid <= report;
            if (report) begin
                period <= cnt;
            end
            if (judge_bad || timeout) begin
                fault    <= 1'b1;
                locked   <= 1'b0;
                good_cnt <= 2'd0;
            end else if (do_lock) begin
                locked   <= 1'b1;
                good_cnt <= 2'd2;
            end else if (report && period_ok && (good_cnt != 2'd2)) begin
                good_cnt <= good_cnt + 2'd1;
            end
        end
    end

`ifdef TICK_MONITOR_DUTY_CHECK_EN
    // Publish the measured high time alongside each period report.
    always_ff @(posedge clkd) begin
        if (!rst_n) begin
            high_time <= '0;
        end else if (report) begin
            high_time <= high_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// Directed testbench for tick_monitor with FREQ_IN=100, FREQ_EXP=5, TOL_PCT=10
// (EXP=20, LO=18, HI=22, TMO=40). Define TICK_MONITOR_DUTY_CHECK_EN for the duty test.
module tb_tick_monitor;

    logic       clkd = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_slow = 1'b0;
    logic       tick;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       fault;
`ifdef TICK_MONITOR_DUTY_CHECK_EN
    logic [7:0] high_time;
    logic [7:0] last_high = 8'd0;
`endif

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pv_count = 0;
    int         tick_count = 0;
    int         tick_cyc = 0;
    logic [7:0] last_period = 8'd0;

    tick_monitor #(
        .FREQ_IN  (100),
        .FREQ_EXP (5),
        .TOL_PCT  (10),
        .CNT_W    (8)
    ) dut (
        .clkd         (clkd),
        .rst_n        (rst_n),
        .clk_slow     (clk_slow),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault)
`ifdef TICK_MONITOR_DUTY_CHECK_EN
        ,
        .high_time    (high_time)
`endif
    );

    // 10-time-unit fast clock.
    always #5 clkd = ~clkd;

    // One fast cycle: sample outputs on the falling edge, then drive the slow input.
    task automatic step(input logic v);
        @(negedge clkd);
        cyc++;
        if (tick) begin
            tick_count++;
            tick_cyc = cyc;
        end
        if (period_valid) begin
            pv_count++;
            last_period = period;
`ifdef TICK_MONITOR_DUTY_CHECK_EN
            last_high = high_time;
`endif
        end
        clk_slow = v;
    endtask

    // One slow period: high for 'high' cycles, then low for the rest of 'len'.
    task automatic slow_cycle(input int len, input int high);
        for (int i = 0; i < len; i++) begin
            step(i < high);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %0b expected 0", tick); end
        checks++; if (period !== 8'd0) begin errors++; $display("[TB] FAIL reset_period got %0d expected 0", period); end
        checks++; if (period_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pv got %0b expected 0", period_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %0b expected 0", locked); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %0b expected 0", fault); end
    endtask

    task automatic test_nominal();
        int e;
        int pv0;
        int tk0;
        pv0 = pv_count;
        tk0 = tick_count;
        e = cyc + 1;
        slow_cycle(20, 10);
        checks++; if (tick_cyc !== e + 3) begin errors++; $display("[TB] FAIL tick_latency got cycle %0d expected %0d", tick_cyc, e + 3); end
        checks++; if (pv_count !== pv0) begin errors++; $display("[TB] FAIL first_rise_no_pv got %0d reports expected %0d", pv_count - pv0, 0); end
        slow_cycle(20, 10);
        checks++; if (last_period !== 8'd20) begin errors++; $display("[TB] FAIL nominal_period got %0d expected 20", last_period); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL not_locked_yet got %0b expected 0", locked); end
        slow_cycle(20, 10);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL locked_third_rise got %0b expected 1", locked); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL nominal_fault got %0b expected 0", fault); end
        checks++; if (pv_count - pv0 !== 2) begin errors++; $display("[TB] FAIL nominal_pv_count got %0d expected 2", pv_count - pv0); end
        checks++; if (tick_count - tk0 !== 3) begin errors++; $display("[TB] FAIL nominal_ticks got %0d expected 3", tick_count - tk0); end
    endtask

    task automatic test_bad_period();
        slow_cycle(25, 10);
        slow_cycle(20, 10);
        checks++; if (last_period !== 8'd25) begin errors++; $display("[TB] FAIL bad_period got %0d expected 25", last_period); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL bad_fault got %0b expected 1", fault); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL bad_unlock got %0b expected 0", locked); end
        slow_cycle(20, 10);
        slow_cycle(20, 10);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL relock got %0b expected 1", locked); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky got %0b expected 1", fault); end
    endtask

    task automatic test_timeout();
        int e;
        int pv0;
        step(1'b1);
        e = cyc;
        for (int i = 0; i < 9; i++) begin
            step(1'b1);
        end
        while (cyc < e + 42) begin
            step(1'b0);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL pre_timeout_locked got %0b expected 1", locked); end
        step(1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL timeout_unlock got %0b expected 0", locked); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL timeout_fault got %0b expected 1", fault); end
        checks++; if (last_period !== 8'd20) begin errors++; $display("[TB] FAIL timeout_period_kept got %0d expected 20", last_period); end
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
        end
        pv0 = pv_count;
        slow_cycle(20, 10);
        checks++; if (pv_count !== pv0) begin errors++; $display("[TB] FAIL idle_rise_no_pv got %0d reports expected 0", pv_count - pv0); end
        slow_cycle(20, 10);
        checks++; if (pv_count - pv0 !== 1) begin errors++; $display("[TB] FAIL after_timeout_pv got %0d reports expected 1", pv_count - pv0); end
    endtask

    task automatic test_mid_reset();
        int pv0;
        slow_cycle(20, 10);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
        end
        pv0 = pv_count;
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        checks++; if (period !== 8'd0) begin errors++; $display("[TB] FAIL midrst_period got %0d expected 0", period); end
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL midrst_fault got %0b expected 0", fault); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL midrst_locked got %0b expected 0", locked); end
        checks++; if ({tick, period_valid} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_pulses got %b expected 00", {tick, period_valid}); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
        end
        slow_cycle(20, 10);
        checks++; if (pv_count !== pv0) begin errors++; $display("[TB] FAIL midrst_first_rise got %0d reports expected 0", pv_count - pv0); end
        slow_cycle(20, 10);
        checks++; if (pv_count - pv0 !== 1) begin errors++; $display("[TB] FAIL midrst_second_rise got %0d reports expected 1", pv_count - pv0); end
        checks++; if (last_period !== 8'd20) begin errors++; $display("[TB] FAIL midrst_period_val got %0d expected 20", last_period); end
    endtask

    task automatic test_boundaries();
        int         lens [4] = '{18, 22, 17, 23};
        logic       exp_lock [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_fault [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp_p;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int j = 0; j < 3; j++) begin
                slow_cycle(lens[k], lens[k] / 2);
            end
            slow_cycle(20, 10);
            exp_p = 8'(lens[k]);
            checks++; if (last_period !== exp_p) begin errors++; $display("[TB] FAIL bound_period_%0d got %0d expected %0d", lens[k], last_period, exp_p); end
            checks++; if (locked !== exp_lock[k]) begin errors++; $display("[TB] FAIL bound_locked_%0d got %0b expected %0b", lens[k], locked, exp_lock[k]); end
            checks++; if (fault !== exp_fault[k]) begin errors++; $display("[TB] FAIL bound_fault_%0d got %0b expected %0b", lens[k], fault, exp_fault[k]); end
        end
    endtask

`ifdef TICK_MONITOR_DUTY_CHECK_EN
    task automatic test_duty();
        do_reset();
        slow_cycle(20, 10);
        slow_cycle(20, 10);
        slow_cycle(20, 14);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL duty_ok_locked got %0b expected 1", locked); end
        checks++; if (last_high !== 8'd10) begin errors++; $display("[TB] FAIL duty_ok_high got %0d expected 10", last_high); end
        slow_cycle(20, 10);
        checks++; if (last_high !== 8'd14) begin errors++; $display("[TB] FAIL duty_bad_high got %0d expected 14", last_high); end
        checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL duty_bad_fault got %0b expected 1", fault); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL duty_bad_locked got %0b expected 0", locked); end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] tick_monitor bench start");
        test_reset();
        test_nominal();
        test_bad_period();
        test_timeout();
        test_mid_reset();
        test_boundaries();
`ifdef TICK_MONITOR_DUTY_CHECK_EN
        test_duty();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
